ram_target: RTL and testbench
=============================

// Module: ram_target
// PURPOSE
//  Synthesizable HyperBus target (device side) answering the ram_phy initiator: decodes CA, serves
//  linear/wrapped bursts from local 16-bit RAM and holds CR0/CR1. For FPGA loopback/emulation of
//  the external RAM; samples the bus by oversampling with the system clock.
// PARAMETERS
//  AW         10      word-address width of local RAM (2**AW x 16 bit)
//  LATENCY    6       initial latency in CK cycles (1x)
//  FIXED_2X   1       1: always 2x latency, RWDS high during CA; 0: always 1x, RWDS low
//  WRAP_WORDS 16      wrapped-burst group size in words (power of 2, <=2**AW)
// PORTS
//  clk          in   1   system clock, must be >= 4x bus CK frequency
//  rst          in   1   asynchronous reset, active low
//  ram_cs       in   1   bus chip select, active low
//  ram_clk      in   1   bus CK
//  ram_adq_i    in   8   bus ADQ input
//  ram_adq_o    out  8   ADQ drive value
//  ram_adq_oe   out  1   ADQ output enable
//  ram_rwds_i   in   1   RWDS input (write byte mask, 1 = masked)
//  ram_rwds_o   out  1   RWDS drive value
//  ram_rwds_oe  out  1   RWDS output enable
//  cr0          out  16  configuration register 0
//  cr1          out  16  configuration register 1
//  busy         out  1   transaction in progress (state != IDLE)
// BEHAVIOUR
//  - Reset: all outputs 0 except cr0=16'h8F1F, cr1=16'h0002; state IDLE; RAM contents undefined.
//  - ram_cs, ram_clk, ram_adq_i, ram_rwds_i pass through one common 2-flop sync chain (alignment kept).
//    CK edge = synced CK differs from its previous sample; each edge carries one byte (DDR).
//  - States: IDLE -> CA -> {LAT, REGW} -> {WDAT, RDAT}; any state -> IDLE within 1 clk of synced
//    cs high; oe outputs drop same cycle as state leaves. cs low in IDLE -> CA.
//  - CA: 6 edges, MSB byte first, into ca[47:0]. ca[47]=read, ca[46]=register space, ca[45]=linear.
//    Word addr = {ca[44:16],ca[2:0]} truncated to AW bits (upper bits ignored, aliasing).
//  - During CA: rwds_oe=1, rwds_o=FIXED_2X. Deasserted on 6th edge.
//  - Register write (ca[47]=0, ca[46]=1): zero latency, REGW takes next 2 edges, MSB first;
//    addr[0]=0 -> cr0, 1 -> cr1; extra edges ignored; cs high after 1 byte -> no update.
//  - Otherwise LAT: count L = LATENCY*(FIXED_2X?2:1) rising CK edges after CA; then data phase.
//  - WDAT: byte pairs (hi on rising, lo on falling edge) form one word; byte enable = !rwds sampled
//    with that byte; write issued on falling edge, address then advances. Partial word at cs-high dropped.
//  - RDAT: target drives adq_oe=1, rwds_oe=1 from start of data phase. Word fetched one edge ahead
//    (RAM read latency 1 clk); on each detected edge target outputs next byte and toggles rwds_o
//    (rising->hi byte with rwds_o=1, falling->lo byte with rwds_o=0), updated 1 clk after edge detect.
//    Register reads return cr0/cr1 by addr[0], then repeat same register.
//  - Address advance: linear -> +1, wraps at 2**AW; wrapped -> low log2(WRAP_WORDS) bits increment
//    modulo, upper bits fixed.
//  - Simultaneous cs rise and CK edge: cs wins, byte discarded. Reset mid-burst: immediate IDLE, oe=0.
// STRUCTURE
//  - Package ram_target_pkg: state enum (IDLE,CA,LAT,REGW,WDAT,RDAT), CA bit-position constants,
//    CR0/CR1 reset values.
//  - Sub-module ram_target_mem: single-port sync RAM, 2**AW x 16, 2-bit byte write enable, 1-clk read.
//  - Top: sync chain, edge detect, FSM, edge/latency counters, address generator, output regs.
// TESTING
//  - Reset then idle: cr0=8F1F, cr1=0002, all oe=0, busy=0; cs pulsed with no CK -> back to IDLE.
//  - Linear write 4 words 1111,2222,3333,4444 @ word 0x010, then linear read 4 @ 0x010 -> same data,
//    RWDS toggles once per byte, first byte after exactly 12 CK (LATENCY=6, 2x).
//  - Masked write 0xABCD @ 0x020 with rwds high on lo byte, prior 0x0000 -> read returns 0xAB00.
//  - Wrapped read 6 words starting 0x01E (group 0x010-0x01F) -> words 1E,1F,10,11,12,13.
//  - Register write cr0=0x8F17 then register read addr 0 -> 0x8F17; 1-byte reg write -> cr0 unchanged.
//  - cs raised mid-read after 3 bytes -> adq_oe/rwds_oe 0 within 3 clk; next transaction correct.

Source files
------------

// File: rtl/ram_target_pkg.sv
// rtl/ram_target_pkg.sv - shared types and constants for the HyperBus RAM target
package ram_target_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CA   = 3'd1,
    LAT  = 3'd2,
    REGW = 3'd3,
    WDAT = 3'd4,
    RDAT = 3'd5
  } state_e;

  // Command/address word layout (48 bits, MSB byte first on the bus)
  localparam int CA_BIT_READ   = 47;
  localparam int CA_BIT_REG    = 46;
  localparam int CA_BIT_LINEAR = 45;
  localparam int CA_EDGES      = 6;

  localparam logic [15:0] CR0_RESET = 16'h8F1F;
  localparam logic [15:0] CR1_RESET = 16'h0002;

  // Full 32-bit word address carried by CA: row/upper column bits plus the low column bits
  function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
    return {ca[44:16], ca[2:0]};
  endfunction

endpackage

// File: rtl/ram_target_mem.sv
// rtl/ram_target_mem.sv - single-port synchronous 16-bit RAM with byte write enables
module ram_target_mem
  import ram_target_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q;

  // Byte-masked write and registered read (old data on a same-cycle write)
  always_ff @(posedge clk_i) begin
    if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_target.sv
// rtl/ram_target.sv - HyperBus device-side target serving bursts from local RAM plus CR0/CR1
module ram_target
  import ram_target_pkg::*;
#(
  parameter int AW         = 10,
  parameter int LATENCY    = 6,
  parameter int FIXED_2X   = 1,
  parameter int WRAP_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_cs,
  input  logic        ram_clk,
  input  logic [7:0]  ram_adq_i,
  output logic [7:0]  ram_adq_o,
  output logic        ram_adq_oe,
  input  logic        ram_rwds_i,
  output logic        ram_rwds_o,
  output logic        ram_rwds_oe,
  output logic [15:0] cr0,
  output logic [15:0] cr1,
  output logic        busy
);

  // Latency is counted in whole CK cycles, i.e. two edges each
  localparam int          LAT_EDGES = 2 * LATENCY * ((FIXED_2X != 0) ? 2 : 1);
  localparam int          CNT_W     = 8;
  localparam logic [AW-1:0] WRAP_MASK = AW'(WRAP_WORDS - 1);

  state_e state_q, state_d;

  logic [10:0]      sync1_q, sync2_q;
  logic             s_cs, s_ck, s_rwds;
  logic [7:0]       s_adq;
  logic             ck_prev_q;
  logic             edge_det, rise, fall;

  logic [CNT_W-1:0] cnt_q;
  logic [39:0]      ca_q;
  logic [47:0]      ca_shift;
  logic [31:0]      ca_addr_full;
  logic             read_q, reg_q, lin_q;
  logic             ca_last;

  logic [AW-1:0]    addr_q, addr_next;
  logic             advance;

  logic [7:0]       hi_q;
  logic             hi_be_q;
  logic [7:0]       lo_q;
  logic [7:0]       adq_q;
  logic             rwds_q;
  logic [15:0]      cr0_q, cr1_q;

  logic [1:0]       mem_we;
  logic [15:0]      mem_wdata, mem_rdata, rd_word;

  logic             unused_ca;

  // Bus inputs share one 2-flop chain so CK, CS, ADQ and RWDS stay aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 11'h400;
      sync2_q <= 11'h400;
    end else begin
      sync1_q <= {ram_cs, ram_clk, ram_rwds_i, ram_adq_i};
      sync2_q <= sync1_q;
    end
  end

  assign s_cs   = sync2_q[10];
  assign s_ck   = sync2_q[9];
  assign s_rwds = sync2_q[8];
  assign s_adq  = sync2_q[7:0];

  // Previous synced CK sample for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ck_prev_q <= 1'b0;
    else      ck_prev_q <= s_ck;
  end

  // A deasserted chip select discards any coincident edge
  assign edge_det = (s_ck != ck_prev_q) && !s_cs;
  assign rise     = edge_det && s_ck;
  assign fall     = edge_det && !s_ck;

  assign ca_shift     = {ca_q, s_adq};
  assign ca_addr_full = ca_word_addr(ca_shift);
  assign ca_last      = (state_q == CA) && edge_det && (cnt_q == CNT_W'(CA_EDGES - 1));
  assign unused_ca    = ^{ca_shift[15:3], ca_addr_full[31:AW]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; synced CS high always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (s_cs) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CA;
        CA: begin
          if (ca_last)
            state_d = (!ca_shift[CA_BIT_READ] && ca_shift[CA_BIT_REG]) ? REGW : LAT;
        end
        LAT: begin
          if (edge_det && cnt_q == CNT_W'(LAT_EDGES - 1))
            state_d = read_q ? RDAT : WDAT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Bus outputs are driven only in CA (RWDS latency flag) and RDAT
  always_comb begin
    ram_adq_o   = 8'h00;
    ram_adq_oe  = 1'b0;
    ram_rwds_o  = 1'b0;
    ram_rwds_oe = 1'b0;
    case (state_q)
      CA: begin
        ram_rwds_oe = 1'b1;
        ram_rwds_o  = (FIXED_2X != 0);
      end
      RDAT: begin
        ram_adq_oe  = 1'b1;
        ram_rwds_oe = 1'b1;
        ram_adq_o   = adq_q;
        ram_rwds_o  = rwds_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign cr0  = cr0_q;
  assign cr1  = cr1_q;

  // Per-state edge counter, cleared on every state change and saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt_q <= '0;
    else if (state_d != state_q)     cnt_q <= '0;
    else if (edge_det && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  // CA shift register and decoded transaction flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ca_q   <= '0;
      read_q <= 1'b0;
      reg_q  <= 1'b0;
      lin_q  <= 1'b0;
    end else if (state_q == CA && edge_det) begin
      ca_q <= ca_shift[39:0];
      if (ca_last) begin
        read_q <= ca_shift[CA_BIT_READ];
        reg_q  <= ca_shift[CA_BIT_REG];
        lin_q  <= ca_shift[CA_BIT_LINEAR];
      end
    end
  end

  // Linear bursts wrap at the RAM size; wrapped bursts stay inside their group
  assign addr_next = lin_q ? addr_q + 1'b1
                           : (addr_q & ~WRAP_MASK) | ((addr_q + 1'b1) & WRAP_MASK);
  assign advance   = ((state_q == WDAT) && fall) ||
                     ((state_q == RDAT) && rise && !reg_q);

  // Word address: loaded at the end of CA, stepped once per data word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         addr_q <= '0;
    else if (ca_last) addr_q <= ca_addr_full[AW-1:0];
    else if (advance) addr_q <= addr_next;
  end

  // High byte (and its enable) captured on rising edges for writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= 8'h00;
      hi_be_q <= 1'b0;
    end else if ((state_q == WDAT || state_q == REGW) && rise) begin
      hi_q    <= s_adq;
      hi_be_q <= !s_rwds;
    end
  end

  assign mem_we    = ((state_q == WDAT) && fall) ? {hi_be_q, !s_rwds} : 2'b00;
  assign mem_wdata = {hi_q, s_adq};

  // Configuration registers take the second register-write byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cr0_q <= CR0_RESET;
      cr1_q <= CR1_RESET;
    end else if (state_q == REGW && edge_det && cnt_q == CNT_W'(1)) begin
      if (addr_q[0]) cr1_q <= {hi_q, s_adq};
      else           cr0_q <= {hi_q, s_adq};
    end
  end

  assign rd_word = reg_q ? (addr_q[0] ? cr1_q : cr0_q) : mem_rdata;

  // Read output bytes: hi with RWDS high on rising, buffered lo with RWDS low on falling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adq_q  <= 8'h00;
      lo_q   <= 8'h00;
      rwds_q <= 1'b0;
    end else if (state_q == IDLE) begin
      adq_q  <= 8'h00;
      rwds_q <= 1'b0;
    end else if (state_q == RDAT && rise) begin
      adq_q  <= rd_word[15:8];
      lo_q   <= rd_word[7:0];
      rwds_q <= 1'b1;
    end else if (state_q == RDAT && fall) begin
      adq_q  <= lo_q;
      rwds_q <= 1'b0;
    end
  end

  ram_target_mem #(.AW(AW)) u_mem (
    .clk_i   (clk),
    .addr_i  (addr_q),
    .we_i    (mem_we),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_ram_target.sv
// tb/tb_ram_target.sv - randomized self-checking bench for ram_target against a word-level model
module tb_ram_target;

  localparam int AW      = 10;
  localparam int DEPTH   = 1024;
  localparam int WRAP    = 16;
  localparam int LCYC    = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ram_cs = 1'b1;
  logic        ram_clk = 1'b0;
  logic [7:0]  ram_adq_i = 8'h00;
  logic        ram_rwds_i = 1'b0;
  logic [7:0]  ram_adq_o;
  logic        ram_adq_oe;
  logic        ram_rwds_o;
  logic        ram_rwds_oe;
  logic [15:0] cr0, cr1;
  logic        busy;

  ram_target #(.AW(AW), .LATENCY(6), .FIXED_2X(1), .WRAP_WORDS(WRAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_cs      (ram_cs),
    .ram_clk     (ram_clk),
    .ram_adq_i   (ram_adq_i),
    .ram_adq_o   (ram_adq_o),
    .ram_adq_oe  (ram_adq_oe),
    .ram_rwds_i  (ram_rwds_i),
    .ram_rwds_o  (ram_rwds_o),
    .ram_rwds_oe (ram_rwds_oe),
    .cr0         (cr0),
    .cr1         (cr1),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] model [DEPTH];
  logic [15:0] cr0_m = 16'h8F1F;
  logic [15:0] cr1_m = 16'h0002;
  logic [15:0] wq[$];
  logic [1:0]  mq[$];
  logic        ca_oe_s, ca_rw_s, post_ca_oe;
  logic        lat_oe_pre, lat_oe_post;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] make_ca(input bit rd, input bit rg, input bit lin,
                                          input logic [31:0] a);
    logic [47:0] c;
    c = '0;
    c[47] = rd;
    c[46] = rg;
    c[45] = lin;
    c[44:16] = a[31:3];
    c[2:0] = a[2:0];
    return c;
  endfunction

  function automatic int next_addr(input int a, input bit lin);
    if (lin) return (a + 1) % DEPTH;
    return (a / WRAP) * WRAP + (a + 1) % WRAP;
  endfunction

  task automatic ck_edge(input logic [7:0] d, input logic m);
    ram_clk    = ~ram_clk;
    ram_adq_i  = d;
    ram_rwds_i = m;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_ca(input logic [47:0] ca);
    ram_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      ck_edge(ca[47-8*i -: 8], 1'b0);
      if (i == 0) begin
        ca_oe_s = ram_rwds_oe;
        ca_rw_s = ram_rwds_o;
      end
    end
    post_ca_oe = ram_rwds_oe;
  endtask

  task automatic lat();
    for (int i = 0; i < 2 * LCYC; i++) begin
      ck_edge(8'h00, 1'b0);
      if (i == 2 * LCYC - 2) lat_oe_pre = ram_adq_oe;
    end
    lat_oe_post = ram_adq_oe;
  endtask

  task automatic end_txn();
    ram_cs = 1'b1;
    repeat (3) @(negedge clk);
    ram_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_burst(input logic [31:0] a, input bit lin);
    int p;
    p = int'(a % DEPTH);
    start_ca(make_ca(1'b0, 1'b0, lin, a));
    lat();
    foreach (wq[i]) begin
      ck_edge(wq[i][15:8], mq[i][1]);
      ck_edge(wq[i][7:0], mq[i][0]);
      if (!mq[i][1]) model[p][15:8] = wq[i][15:8];
      if (!mq[i][0]) model[p][7:0]  = wq[i][7:0];
      p = next_addr(p, lin);
    end
    end_txn();
  endtask

  // Leaves CS low so the caller can end or abort the transfer
  task automatic read_burst(input logic [31:0] a, input bit lin, input bit rg,
                            input int nbytes, input string tag);
    int p;
    logic [15:0] w;
    p = int'(a % DEPTH);
    start_ca(make_ca(1'b1, rg, lin, a));
    lat();
    for (int i = 0; i < nbytes; i++) begin
      ck_edge(8'h00, 1'b0);
      w = rg ? (a[0] ? cr1_m : cr0_m) : model[p];
      check($sformatf("%s_b%0d", tag, i), ram_adq_o, (i % 2 == 0) ? w[15:8] : w[7:0]);
      check($sformatf("%s_rwds%0d", tag, i), ram_rwds_o, (i % 2 == 0) ? 1 : 0);
      check($sformatf("%s_oe%0d", tag, i), {ram_adq_oe, ram_rwds_oe}, 2'b11);
      if (i % 2 == 1 && !rg) p = next_addr(p, lin);
    end
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [15:0] v, input int nb);
    start_ca(make_ca(1'b0, 1'b1, 1'b0, a));
    ck_edge(v[15:8], 1'b0);
    if (nb > 1) ck_edge(v[7:0], 1'b0);
    end_txn();
    if (nb > 1) begin
      if (a[0]) cr1_m = v;
      else      cr0_m = v;
    end
  endtask

  initial begin
    int base, n;
    bit lin;
    logic [31:0] a;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_cr0", cr0, 16'h8F1F);
    check("rst_cr1", cr1, 16'h0002);
    check("rst_oe", {ram_adq_oe, ram_rwds_oe}, 2'b00);
    check("rst_out", {ram_adq_o, ram_rwds_o}, 9'h000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // CS pulse with no CK
    ram_cs = 1'b0;
    repeat (4) @(negedge clk);
    check("pulse_busy", busy, 1'b1);
    ram_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("pulse_idle", busy, 1'b0);
    check("pulse_oe", {ram_adq_oe, ram_rwds_oe}, 2'b00);

    // Fill words 0..127 with random data
    wq.delete(); mq.delete();
    for (int i = 0; i < 128; i++) begin
      wq.push_back(16'($urandom));
      mq.push_back(2'b00);
    end
    write_burst(32'h0, 1'b1);

    // Linear write then read back, with CA RWDS and exact latency checks
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    mq = '{2'b00, 2'b00, 2'b00, 2'b00};
    write_burst(32'h010, 1'b1);
    check("ca_rwds_oe", ca_oe_s, 1'b1);
    check("ca_rwds_o", ca_rw_s, 1'b1);
    check("post_ca_oe", post_ca_oe, 1'b0);
    read_burst(32'h010, 1'b1, 1'b0, 8, "lin");
    check("lat_oe_pre", lat_oe_pre, 1'b0);
    check("lat_oe_post", lat_oe_post, 1'b1);
    end_txn();

    // Masked write: low byte masked over prior zero
    wq = '{16'h0000}; mq = '{2'b00};
    write_burst(32'h020, 1'b1);
    wq = '{16'hABCD}; mq = '{2'b01};
    write_burst(32'h020, 1'b1);
    read_burst(32'h020, 1'b1, 1'b0, 2, "mask");
    end_txn();

    // Wrapped read crossing the group boundary
    read_burst(32'h01E, 1'b0, 1'b0, 12, "wrap");
    end_txn();

    // Register write/read, and a 1-byte register write that must not land
    reg_write(32'h0, 16'h8F17, 2);
    check("cr0_wr", cr0, 16'h8F17);
    read_burst(32'h0, 1'b1, 1'b1, 4, "regrd0");
    end_txn();
    reg_write(32'h0, 16'h1234, 1);
    check("cr0_1byte", cr0, 16'h8F17);
    reg_write(32'h1, 16'h00C5, 2);
    check("cr1_wr", cr1, 16'h00C5);
    read_burst(32'h1, 1'b1, 1'b1, 4, "regrd1");
    end_txn();

    // Abort mid-read, then a clean transaction
    read_burst(32'h010, 1'b1, 1'b0, 3, "abort");
    ram_cs = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_oe", {ram_adq_oe, ram_rwds_oe}, 2'b00);
    check("abort_busy", busy, 1'b0);
    end_txn();
    read_burst(32'h011, 1'b1, 1'b0, 6, "after_abort");
    end_txn();

    // Random bursts with aliased upper address bits
    for (int t = 0; t < 24; t++) begin
      n    = $urandom_range(1, 6);
      lin  = 1'($urandom_range(0, 1));
      base = $urandom_range(0, 127 - n);
      a    = 32'(base) | (32'($urandom_range(0, 255)) << AW);
      if ($urandom_range(0, 1) == 0) begin
        wq.delete(); mq.delete();
        for (int i = 0; i < n; i++) begin
          wq.push_back(16'($urandom));
          mq.push_back(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end
        write_burst(a, lin);
      end else begin
        read_burst(a, lin, 1'b0, 2 * n, $sformatf("rnd%0d", t));
        end_txn();
      end
    end

    // Reset mid-burst
    start_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h010));
    lat();
    ck_edge(8'h00, 1'b0);
    check("pre_rst_oe", ram_adq_oe, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_mid_oe", {ram_adq_oe, ram_rwds_oe}, 2'b00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_cr0", cr0, 16'h8F1F);
    cr0_m = 16'h8F1F;
    cr1_m = 16'h0002;
    ram_cs = 1'b1;
    ram_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    read_burst(32'h012, 1'b1, 1'b0, 4, "post_rst");
    end_txn();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
